// File: rtl/julia_mem_ctrl_if.sv
// julia_mem_ctrl_if: worker result channels plus the single external write port.
// master = workers/writer side, slave = the memory controller.
interface julia_mem_ctrl_if #(
   parameter int NUM_WORKERS = 16,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32
);
   logic [NUM_WORKERS-1:0]             jw_mc_done;
   logic [NUM_WORKERS-1:0][DATA_W-1:0] color;
   logic [NUM_WORKERS-1:0][ADDR_W-1:0] address;
   logic [NUM_WORKERS-1:0]             mc_jw_busy;
   logic [NUM_WORKERS-1:0]             mc_jw_done;
   logic [ADDR_W-1:0]                  wr_addr;
   logic [DATA_W-1:0]                  wr_data;
   logic                               wr_ready;
   logic                               wr_done;
   logic                               frame_done;
   modport master (
      output jw_mc_done, color, address, wr_done,
      input  mc_jw_busy, mc_jw_done, wr_addr, wr_data, wr_ready, frame_done
   );
   modport slave (
      input  jw_mc_done, color, address, wr_done,
      output mc_jw_busy, mc_jw_done, wr_addr, wr_data, wr_ready, frame_done
   );
endinterface

// File: rtl/julia_mem_ctrl.sv
// julia_mem_ctrl: round-robin collector of julia worker results onto one external write port,
// with per-frame pixel counting.
module julia_mem_ctrl #(
   parameter int NUM_WORKERS  = 16,
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int FRAME_PIXELS = 307200
) (
   input logic             clk,
   input logic             n_rst,
   julia_mem_ctrl_if.slave bus
);
   localparam int IW = NUM_WORKERS > 1 ? $clog2(NUM_WORKERS) : 1;
   localparam int CW = FRAME_PIXELS > 1 ? $clog2(FRAME_PIXELS) : 1;
   typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;
   state_t            r_state, w_next;
   logic [IW-1:0]     r_rr, w_gnt, w_idx;
   logic [CW-1:0]     r_cnt;
   logic              r_fd;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [NUM_WORKERS-1:0] w_sel;
   logic              w_any, w_last;
   assign w_any  = |bus.jw_mc_done;
   assign w_last = r_cnt == CW'(FRAME_PIXELS - 1);
   assign w_sel  = NUM_WORKERS'(1) << r_rr;
   // Scan downward in distance so the nearest requester above r_rr wins.
   always_comb begin
      w_gnt = r_rr;
      w_idx = r_rr;
      for (int k = NUM_WORKERS; k >= 1; k--) begin
         w_idx = IW'((int'(r_rr) + k) % NUM_WORKERS);
         if (bus.jw_mc_done[w_idx]) w_gnt = w_idx;
      end
   end
   always_comb begin
      w_next = r_state == IDLE  ? (w_any ? WRITE : IDLE) :
               r_state == WRITE ? (bus.wr_done ? ACK : WRITE) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (n_rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_rr   <= IW'(NUM_WORKERS - 1);
         r_cnt  <= '0;
         r_fd   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         if (r_state == IDLE && w_any) begin
            r_rr   <= w_gnt;
            r_addr <= bus.address[w_gnt];
            r_data <= bus.color[w_gnt];
         end
         if (r_state == WRITE && bus.wr_done) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            r_fd  <= w_last;
         end
      end
   end
   assign bus.wr_ready   = r_state == WRITE;
   assign bus.mc_jw_busy = r_state == WRITE ? w_sel : '0;
   assign bus.mc_jw_done = r_state == ACK ? w_sel : '0;
   assign bus.frame_done = r_state == ACK && r_fd;
   assign bus.wr_addr    = r_addr;
   assign bus.wr_data    = r_data;
endmodule

// File: tb/tb_julia_mem_ctrl.sv
// tb_julia_mem_ctrl: directed and random stimulus for julia_mem_ctrl, checked every cycle
// against a transaction-level reference model (FRAME_PIXELS=4).
module tb_julia_mem_ctrl;
   localparam int NW = 16;
   localparam int FP = 4;
   logic clk = 1'b0;
   logic n_rst = 1'b1;
   julia_mem_ctrl_if #(.NUM_WORKERS(NW), .DATA_W(32), .ADDR_W(32)) bus ();
   julia_mem_ctrl #(.NUM_WORKERS(NW), .DATA_W(32), .ADDR_W(32), .FRAME_PIXELS(FP)) dut (
      .clk(clk), .n_rst(n_rst), .bus(bus));
   always #5 clk = ~clk;
   typedef enum int {M_IDLE, M_BUSY, M_RELEASE} mphase_t;
   int total = 0, bad = 0, fd_seen = 0;
   mphase_t m_phase = M_IDLE;
   int m_cur = 0, m_last = NW - 1, m_pix = 0;
   bit m_fd = 1'b0;
   logic [31:0] m_addr = '0, m_data = '0;
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // Round-robin: first requester strictly above the last grant, else the lowest one.
   function automatic int pick(logic [NW-1:0] r, int last);
      for (int i = last + 1; i < NW; i++) if (r[i]) return i;
      for (int i = 0; i <= last; i++) if (r[i]) return i;
      return -1;
   endfunction
   task automatic tick();
      int g;
      if (n_rst) begin
         m_phase = M_IDLE; m_last = NW - 1; m_pix = 0; m_fd = 1'b0; m_addr = '0; m_data = '0; m_cur = 0;
      end else if (m_phase == M_IDLE) begin
         g = pick(bus.jw_mc_done, m_last);
         if (g >= 0) begin
            m_cur = g; m_last = g; m_addr = bus.address[g]; m_data = bus.color[g]; m_phase = M_BUSY;
         end
      end else if (m_phase == M_BUSY) begin
         if (bus.wr_done) begin
            m_pix++;
            m_fd = (m_pix % FP) == 0;
            m_phase = M_RELEASE;
         end
      end else m_phase = M_IDLE;
      @(posedge clk); #1;
      chk("wr_ready", 64'(bus.wr_ready), 64'(m_phase == M_BUSY));
      chk("busy", 64'(bus.mc_jw_busy), m_phase == M_BUSY ? 64'(1) << m_cur : 64'd0);
      chk("done", 64'(bus.mc_jw_done), m_phase == M_RELEASE ? 64'(1) << m_cur : 64'd0);
      chk("frame_done", 64'(bus.frame_done), 64'(m_phase == M_RELEASE && m_fd));
      if (m_phase == M_BUSY || n_rst) begin
         chk("wr_addr", 64'(bus.wr_addr), 64'(m_addr));
         chk("wr_data", 64'(bus.wr_data), 64'(m_data));
      end
      if (bus.frame_done) fd_seen++;
      if (m_phase == M_RELEASE) bus.jw_mc_done[m_cur] = 1'b0;
   endtask
   task automatic one_write(int w);
      bus.color[w] = $urandom;
      bus.address[w] = $urandom;
      bus.jw_mc_done[w] = 1'b1;
      bus.wr_done = 1'b1;
      repeat (3) tick();
      bus.wr_done = 1'b0;
   endtask
   int exp_a[3] = '{'h1, 'h20, 'h8000};
   int exp_b[2] = '{'h1, 'h8000};
   initial begin
      bus.jw_mc_done = '0; bus.color = '0; bus.address = '0; bus.wr_done = 1'b0;
      repeat (2) tick();
      n_rst = 1'b0;
      bus.color[3] = 32'h00FF00FF; bus.address[3] = 32'h1000; bus.jw_mc_done[3] = 1'b1;
      tick();
      chk("single_busy", 64'(bus.mc_jw_busy), 64'h8);
      chk("single_addr", 64'(bus.wr_addr), 64'h1000);
      chk("single_data", 64'(bus.wr_data), 64'h00FF00FF);
      repeat (2) tick();
      bus.wr_done = 1'b1;
      tick();
      bus.wr_done = 1'b0;
      chk("single_done", 64'(bus.mc_jw_done), 64'h8);
      chk("single_rdy_low", 64'(bus.wr_ready), 64'h0);
      tick();
      chk("single_done_once", 64'(bus.mc_jw_done), 64'h0);
      n_rst = 1'b1; tick(); n_rst = 1'b0;
      bus.jw_mc_done = 16'h8021;
      bus.wr_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rr_order_a", 64'(bus.mc_jw_busy), 64'(exp_a[i]));
         repeat (2) tick();
      end
      bus.jw_mc_done = 16'h8001;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rr_order_b", 64'(bus.mc_jw_busy), 64'(exp_b[i]));
         repeat (2) tick();
      end
      bus.wr_done = 1'b0;
      bus.color[9] = 32'h12345678; bus.address[9] = 32'h2468; bus.jw_mc_done[9] = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         if (i == 10) bus.color[9] = 32'hDEADBEEF;
         tick();
         chk("stall_data", 64'(bus.wr_data), 64'h12345678);
      end
      bus.wr_done = 1'b1;
      repeat (2) tick();
      bus.wr_done = 1'b0;
      n_rst = 1'b1; tick(); n_rst = 1'b0;
      fd_seen = 0;
      one_write(0);
      one_write(1);
      bus.wr_done = 1'b1;
      repeat (4) tick();
      chk("spurious_no_done", 64'(bus.mc_jw_done), 64'h0);
      bus.wr_done = 1'b0;
      for (int i = 2; i < 9; i++) one_write(i);
      chk("frame_pulses_9", 64'(fd_seen), 64'd2);
      for (int i = 9; i < 12; i++) one_write(i);
      chk("frame_pulses_12", 64'(fd_seen), 64'd3);
      bus.color[7] = 32'hA5A5A5A5; bus.address[7] = 32'h7000; bus.jw_mc_done[7] = 1'b1;
      repeat (2) tick();
      n_rst = 1'b1;
      tick();
      chk("rst_mid_rdy", 64'(bus.wr_ready), 64'h0);
      chk("rst_mid_done", 64'(bus.mc_jw_done), 64'h0);
      n_rst = 1'b0;
      fd_seen = 0;
      tick();
      chk("rst_regrant", 64'(bus.mc_jw_busy), 64'h80);
      bus.wr_done = 1'b1;
      repeat (2) tick();
      bus.wr_done = 1'b0;
      for (int i = 0; i < 3; i++) one_write(i);
      chk("rst_count_restart", 64'(fd_seen), 64'd1);
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NW; i++)
            if (!bus.jw_mc_done[i] && $urandom_range(0, 7) == 0) begin
               bus.color[i] = $urandom;
               bus.address[i] = $urandom;
               bus.jw_mc_done[i] = 1'b1;
            end
         if (m_phase == M_BUSY && $urandom_range(0, 9) == 0) bus.color[m_cur] = $urandom;
         bus.wr_done = $urandom_range(0, 2) == 0;
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
